// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : bus_pkg
//  Description : Shared bus defaults and a constant clog2 helper used by the
//                bus blocks.
//  Revision    : 1.0  initial release
// ============================================================================
package bus_pkg;

    localparam int c_word_default = 16;
    localparam int c_n_default    = 9;

    // Ceiling log2; clog2(1) = 0, clog2(9) = 4.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin search. Starts at the index after
//                the pointer, ascends and wraps N-1 -> 0; one-hot winner.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter
    import bus_pkg::*;
#(
    parameter int N  = c_n_default,
    parameter int PW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] pointer,
    output logic [N-1:0]  winner
);

    // One extra bit so pointer + offset (at most 2N-1) cannot overflow.
    logic [PW:0]   w_sum;
    logic [PW-1:0] w_idx;
    logic          w_found;

    always_comb begin
        winner  = '0;
        w_found = 1'b0;
        w_sum   = '0;
        w_idx   = '0;
        for (int off = 1; off <= N; off++) begin
            w_sum = {1'b0, pointer} + (PW+1)'(off);
            if (w_sum >= (PW+1)'(N)) begin
                w_sum = w_sum - (PW+1)'(N);
            end
            w_idx = w_sum[PW-1:0];
            if (!w_found && req[w_idx]) begin
                winner[w_idx] = 1'b1;
                w_found       = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bus_arb_mux.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arb_mux
//  Description : N-source round-robin bus arbiter with registered one-hot
//                grant and combinational data mux. Optional grant locking is
//                enabled by defining BUS_ARB_LOCK_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module bus_arb_mux
    import bus_pkg::*;
#(
    parameter int WORD     = c_word_default,
    parameter int N        = c_n_default,
    parameter int MAX_LOCK = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N-1:0]      req,
    input  logic [N-1:0]      lock,
    input  logic [WORD*N-1:0] src,
    output logic [N-1:0]      grant,
    output logic [WORD-1:0]   bus,
    output logic              bus_valid
);

    localparam int c_pw = clog2(N);

    logic [N-1:0]    r_grant;
    logic [c_pw-1:0] r_ptr;
    logic [N-1:0]    w_winner;
    logic [c_pw-1:0] w_win_idx;
    logic            w_hold;
    logic [WORD-1:0] w_bus;

    // The pointer holds the last winner, so the current owner is naturally
    // lowest priority whenever arbitration runs.
    rr_arbiter #(
        .N  (N),
        .PW (c_pw)
    ) u_rr_arbiter (
        .req     (req),
        .pointer (r_ptr),
        .winner  (w_winner)
    );

`ifdef BUS_ARB_LOCK_EN
    localparam int              c_cw       = clog2(MAX_LOCK + 1);
    localparam logic [c_cw-1:0] c_max_lock = c_cw'(MAX_LOCK);

    logic [c_cw-1:0] r_lock_cnt;

    // Grant is one-hot, so this picks out req/lock of the owner only.
    assign w_hold = (|(r_grant & req & lock)) && (r_lock_cnt < c_max_lock);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_lock_cnt <= '0;
        end else if (w_hold) begin
            r_lock_cnt <= r_lock_cnt + c_cw'(1);
        end else begin
            r_lock_cnt <= '0;
        end
    end
`else
    localparam int c_max_lock_unused = MAX_LOCK;

    // Lock port is kept for pin compatibility but has no effect here.
    logic w_lock_unused;
    assign w_lock_unused = ^lock;
    assign w_hold        = 1'b0;
`endif

    always_comb begin
        w_win_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (w_winner[i]) begin
                w_win_idx = c_pw'(i);
            end
        end
    end

    // Pointer resets to N-1 so the first search begins at source 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_grant <= '0;
            r_ptr   <= c_pw'(N - 1);
        end else if (!w_hold) begin
            r_grant <= w_winner;
            if (|w_winner) begin
                r_ptr <= w_win_idx;
            end
        end
    end

    always_comb begin
        w_bus = '0;
        for (int i = 0; i < N; i++) begin
            if (r_grant[i]) begin
                w_bus = w_bus | src[i*WORD +: WORD];
            end
        end
    end

    assign grant     = r_grant;
    assign bus       = w_bus;
    assign bus_valid = |r_grant;

endmodule
`default_nettype wire

// File: tb/tb_bus_arb_mux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_arb_mux
//  Description : Scoreboard bench for bus_arb_mux with a queue-fed monitor,
//                directed scenarios and randomized traffic.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bus_arb_mux;

    localparam int W  = 16;
    localparam int N  = 9;
    localparam int ML = 8;

    logic           clock;
    logic           reset;
    logic [N-1:0]   req;
    logic [N-1:0]   lock;
    logic [W*N-1:0] src;
    logic [N-1:0]   grant;
    logic [W-1:0]   bus;
    logic           bus_valid;

    int total;
    int bad;

    typedef struct {
        logic [N-1:0] g;
        logic [W-1:0] b;
    } exp_t;

    exp_t exp_q[$];

    // Reference state: owner index (-1 idle), last winner, held-cycle count.
    int m_cur;
    int m_last;
    int m_cnt;

    bus_arb_mux #(
        .WORD     (W),
        .N        (N),
        .MAX_LOCK (ML)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .lock      (lock),
        .src       (src),
        .grant     (grant),
        .bus       (bus),
        .bus_valid (bus_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got running want finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total = total + 1;
        if (act !== want) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, want, $time);
        end
    endtask

    function automatic logic [W*N-1:0] rand_src();
        logic [W*N-1:0] s;
        for (int i = 0; i < N; i++) s[i*W +: W] = W'($urandom);
        return s;
    endfunction

    // Next-edge grant from the arbitration rules: hold a locked owner within
    // its budget, otherwise search ascending from the slot after the last winner.
    task automatic model_step(input logic r, input logic [N-1:0] rq, input logic [N-1:0] lk);
        int win;
        if (r) begin
            m_cur  = -1;
            m_last = N - 1;
            m_cnt  = 0;
            return;
        end
`ifdef BUS_ARB_LOCK_EN
        if (m_cur >= 0 && rq[m_cur] && lk[m_cur] && m_cnt < ML) begin
            m_cnt = m_cnt + 1;
            return;
        end
`endif
        m_cnt = 0;
        win   = -1;
        for (int off = 1; off <= N; off++) begin
            if (win < 0 && rq[(m_last + off) % N]) win = (m_last + off) % N;
        end
        m_cur = win;
        if (win >= 0) m_last = win;
    endtask

    // Called just after a rising edge: pushes what the DUT shows now, applies
    // new inputs, advances the model, and returns just after the next edge.
    task automatic drive(input logic r, input logic [N-1:0] rq, input logic [N-1:0] lk,
                         input logic [W*N-1:0] s);
        exp_t e;
        reset = r;
        req   = rq;
        lock  = lk;
        src   = s;
        e.g = '0;
        e.b = '0;
        if (m_cur >= 0) begin
            e.g[m_cur] = 1'b1;
            e.b        = s[m_cur*W +: W];
        end
        exp_q.push_back(e);
        model_step(r, rq, lk);
        @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_grant", 32'(grant), 32'(e.g));
            chk("sb_bus", 32'(bus), 32'(e.b));
            chk("sb_valid", 32'(bus_valid), 32'(|e.g));
        end
    end

    initial begin
        logic [W*N-1:0] s;
        logic [N-1:0]   one;
        logic [N-1:0]   want;
        logic [N-1:0]   rq;
        logic [N-1:0]   lk;
        logic           rr;

        total  = 0;
        bad    = 0;
        m_cur  = -1;
        m_last = N - 1;
        m_cnt  = 0;
        one    = N'(1);
        reset  = 1'b1;
        req    = '0;
        lock   = '0;
        src    = '0;
        @(posedge clock);
        #1;

        // Idle after a two-cycle reset.
        drive(1'b1, '0, '0, rand_src());
        drive(1'b1, '0, '0, rand_src());
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_bus", 32'(bus), 32'h0);
        chk("rst_valid", 32'(bus_valid), 32'h0);
        drive(1'b0, '0, '0, rand_src());
        chk("idle_grant", 32'(grant), 32'h0);

        // Single requester.
        s = rand_src();
        s[2*W +: W] = 16'hA5A5;
        drive(1'b0, 9'h004, '0, s);
        chk("single_grant", 32'(grant), 32'h004);
        chk("single_bus", 32'(bus), 32'hA5A5);
        chk("single_valid", 32'(bus_valid), 32'h1);
        drive(1'b0, '0, '0, rand_src());
        chk("release_idle", 32'(grant), 32'h0);

        // Full rotation with everyone requesting.
        drive(1'b1, '0, '0, rand_src());
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 9'h1FF, '0, rand_src());
            want = one << (i % N);
            chk("rotate", 32'(grant), 32'(want));
        end

        // Lock budget on source 0 against source 1.
        drive(1'b1, '0, '0, rand_src());
        for (int i = 0; i < 12; i++) begin
            drive(1'b0, 9'h003, 9'h001, rand_src());
`ifdef BUS_ARB_LOCK_EN
            want = (i < 9) ? 9'h001 : ((i == 9) ? 9'h002 : 9'h001);
`else
            want = (i % 2 == 0) ? 9'h001 : 9'h002;
`endif
            chk("lock_seq", 32'(grant), 32'(want));
        end

        // Owner drops req while another request is pending: no idle gap.
        drive(1'b1, '0, '0, rand_src());
        drive(1'b0, 9'h014, '0, rand_src());
        chk("nogap_first", 32'(grant), 32'h004);
        drive(1'b0, 9'h010, '0, rand_src());
        chk("nogap_next", 32'(grant), 32'h010);

        // Reset pulse during a lock.
        drive(1'b1, '0, '0, rand_src());
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 9'h003, 9'h001, rand_src());
`ifdef BUS_ARB_LOCK_EN
            chk("midlock_hold", 32'(grant), 32'h001);
`endif
        end
        drive(1'b1, 9'h003, 9'h001, rand_src());
        chk("midlock_reset", 32'(grant), 32'h0);
        drive(1'b0, 9'h003, 9'h001, rand_src());
        chk("midlock_after", 32'(grant), 32'h001);

        // Randomized traffic with sticky requests so locks can time out.
        rq = N'($urandom);
        lk = N'($urandom);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) rq = N'($urandom) & N'($urandom);
            if ($urandom_range(0, 5) == 0) lk = N'($urandom);
            rr = ($urandom_range(0, 49) == 0);
            drive(rr, rq, lk, rand_src());
        end
        drive(1'b0, '0, '0, rand_src());
        chk("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
